vita_rx_sample_control: RTL and testbench

- Receive-side stream controller for the VITA RX path.
- Accepts timed or immediate streaming commands over the settings bus and queues them in an internal command FIFO.
- Asserts run to the DSP chain, captures strobed samples with a 64-bit timestamp, and pushes them with status flags into a sample FIFO interface consumed by the downstream VITA framer.
- Flags command errors as single status entries: late command, broken chain, overrun, zero-length.

---
 rtl/vita_rx_sample_control.sv | 259 +++++++++++++++++++++++++
 tb/tb_vita_rx_sample_control.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita_rx_sample_control.sv
// vita_rx_sample_control: settings-bus command queue that gates DSP run and feeds a sample FIFO with timestamps and status flags.
// Optional feature under `VITA_RX_RELOAD_EN: a command with reload=1 repeats its block until another command is queued.
`timescale 1ns/1ps
module vita_rx_sample_control #(
  parameter int BASE           = 0,
  parameter int WIDTH          = 32,
  parameter int CMD_DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [63:0]       vita_time,
  output logic              overrun,
  output logic [68+WIDTH:0] sample_fifo_o,
  input  logic              sample_fifo_dst_rdy_i,
  output logic              sample_fifo_src_rdy_o,
  input  logic [WIDTH-1:0]  sample,
  output logic              run,
  input  logic              strobe
);

  localparam int         DEPTH     = 1 << CMD_DEPTH_LOG2;
  localparam logic [7:0] ADDR_CMD  = 8'(BASE);
  localparam logic [7:0] ADDR_SECS = 8'(BASE + 1);
  localparam logic [7:0] ADDR_TICS = 8'(BASE + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAITING, S_RUNNING, S_ZEROLEN, S_LATECMD, S_BROKENCHAIN, S_OVERRUN
  } state_t;

  state_t state, next_state;

  // Settings registers survive clear; only reset wipes them.
  logic [31:0] cmd_word, secs_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_word  <= '0;
      secs_word <= '0;
    end else if (set_stb) begin
      if (set_addr == ADDR_CMD)  cmd_word  <= set_data;
      if (set_addr == ADDR_SECS) secs_word <= set_data;
    end
  end

  // Command FIFO: {cmd, secs, tics}; pointers carry one extra wrap bit.
  logic [95:0]             cmd_mem [DEPTH];
  logic [CMD_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                    cmd_empty, cmd_full, cmd_push, cmd_pop, cmd_flush;
  logic [95:0]             head;

  assign cmd_empty = (wr_ptr == rd_ptr);
  assign cmd_full  = (wr_ptr[CMD_DEPTH_LOG2] != rd_ptr[CMD_DEPTH_LOG2]) &&
                     (wr_ptr[CMD_DEPTH_LOG2-1:0] == rd_ptr[CMD_DEPTH_LOG2-1:0]);
  assign cmd_push  = set_stb && (set_addr == ADDR_TICS) && !cmd_full;
  assign head      = cmd_mem[rd_ptr[CMD_DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[wr_ptr[CMD_DEPTH_LOG2-1:0]] <= {cmd_word, secs_word, set_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear || cmd_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (cmd_push) wr_ptr <= wr_ptr + 1'b1;
      if (cmd_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic        head_imm, head_chain, head_reload;
  logic [28:0] head_lines;
  logic [63:0] head_time;
  assign head_imm    = head[95];
  assign head_chain  = head[94];
  assign head_reload = head[93];
  assign head_lines  = head[92:64];
  assign head_time   = head[63:0];

  logic        cur_imm, cur_chain, nxt_imm, nxt_chain;
  logic [63:0] cur_time, nxt_time;
  logic [28:0] lines_left, nxt_lines_left;
  logic        reload_cont, reload_stop;

`ifdef VITA_RX_RELOAD_EN
  logic        cur_reload, nxt_reload;
  logic [28:0] cur_lines, nxt_lines;

  // A queued command (pushed while streaming) ends the repeat after the current block.
  assign reload_cont = cur_reload && cmd_empty;
  assign reload_stop = cur_reload && !cmd_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_reload <= 1'b0;
      cur_lines  <= '0;
    end else if (clear) begin
      cur_reload <= 1'b0;
      cur_lines  <= '0;
    end else begin
      cur_reload <= nxt_reload;
      cur_lines  <= nxt_lines;
    end
  end
`else
  logic unused_head_reload;
  assign unused_head_reload = head_reload;
  assign reload_cont        = 1'b0;
  assign reload_stop        = 1'b0;
`endif

  logic             o_zero, o_late, o_broken, o_ovf, o_eob, src_rdy;
  logic [63:0]      o_time;
  logic [WIDTH-1:0] o_sample;

  // Handshake: an entry transfers on a rising edge where sample_fifo_src_rdy_o and
  // sample_fifo_dst_rdy_i are both high. Status entries hold until accepted; a running
  // sample cannot wait, so a strobe without dst_rdy is reported as an overrun instead.
  always_comb begin
    next_state     = state;
    nxt_imm        = cur_imm;
    nxt_chain      = cur_chain;
    nxt_time       = cur_time;
    nxt_lines_left = lines_left;
`ifdef VITA_RX_RELOAD_EN
    nxt_reload     = cur_reload;
    nxt_lines      = cur_lines;
`endif
    cmd_pop   = 1'b0;
    cmd_flush = 1'b0;
    src_rdy   = 1'b0;
    o_zero    = 1'b0;
    o_late    = 1'b0;
    o_broken  = 1'b0;
    o_ovf     = 1'b0;
    o_eob     = 1'b0;
    o_time    = '0;
    o_sample  = '0;
    case (state)
      S_IDLE: begin
        if (!cmd_empty) begin
          cmd_pop        = 1'b1;
          nxt_imm        = head_imm;
          nxt_chain      = head_chain;
          nxt_time       = head_time;
          nxt_lines_left = head_lines;
`ifdef VITA_RX_RELOAD_EN
          nxt_reload     = head_reload;
          nxt_lines      = head_lines;
`endif
          next_state     = (head_lines == '0) ? S_ZEROLEN : S_WAITING;
        end
      end
      S_WAITING: begin
        if (cur_imm || (vita_time == cur_time)) next_state = S_RUNNING;
        else if (vita_time > cur_time)          next_state = S_LATECMD;
      end
      S_RUNNING: begin
        if (strobe) begin
          if (!sample_fifo_dst_rdy_i) begin
            next_state = S_OVERRUN;
          end else begin
            src_rdy  = 1'b1;
            o_time   = vita_time;
            o_sample = sample;
            if (lines_left != '0) nxt_lines_left = lines_left - 29'd1;
            if (lines_left == 29'd1) begin
              if (reload_cont) begin
`ifdef VITA_RX_RELOAD_EN
                nxt_lines_left = cur_lines;
`endif
              end else if (reload_stop || !cur_chain) begin
                o_eob      = 1'b1;
                next_state = S_IDLE;
              end else if (!cmd_empty) begin
                // Chained follow-up: its time and send_imm do not apply.
                cmd_pop = 1'b1;
                if (head_lines != '0) begin
                  nxt_lines_left = head_lines;
                  nxt_chain      = head_chain;
`ifdef VITA_RX_RELOAD_EN
                  nxt_reload     = head_reload;
                  nxt_lines      = head_lines;
`endif
                end else begin
                  o_eob      = 1'b1;
                  next_state = S_IDLE;
                end
              end else begin
                next_state = S_BROKENCHAIN;
              end
            end
          end
        end
      end
      S_ZEROLEN, S_LATECMD, S_BROKENCHAIN, S_OVERRUN: begin
        src_rdy  = 1'b1;
        o_eob    = 1'b1;
        o_time   = vita_time;
        o_zero   = (state == S_ZEROLEN);
        o_late   = (state == S_LATECMD);
        o_broken = (state == S_BROKENCHAIN);
        o_ovf    = (state == S_OVERRUN);
        if (sample_fifo_dst_rdy_i) begin
          next_state = S_IDLE;
          cmd_flush  = (state == S_OVERRUN) || (state == S_BROKENCHAIN);
        end
      end
      default: next_state = S_IDLE;
    endcase
    if (clear) begin
      src_rdy  = 1'b0;
      o_zero   = 1'b0;
      o_late   = 1'b0;
      o_broken = 1'b0;
      o_ovf    = 1'b0;
      o_eob    = 1'b0;
      o_time   = '0;
      o_sample = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cur_imm    <= 1'b0;
      cur_chain  <= 1'b0;
      cur_time   <= '0;
      lines_left <= '0;
      overrun    <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      cur_imm    <= 1'b0;
      cur_chain  <= 1'b0;
      cur_time   <= '0;
      lines_left <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= next_state;
      cur_imm    <= nxt_imm;
      cur_chain  <= nxt_chain;
      cur_time   <= nxt_time;
      lines_left <= nxt_lines_left;
      overrun    <= (state == S_RUNNING) && (next_state == S_OVERRUN);
    end
  end

  assign run                   = (state == S_RUNNING) && !clear;
  assign sample_fifo_src_rdy_o = src_rdy;
  assign sample_fifo_o         = {o_zero, o_late, o_broken, o_ovf, o_eob, o_time, o_sample};

endmodule

// File: tb/tb_vita_rx_sample_control.sv
// Testbench for vita_rx_sample_control: command-level reference model feeds an expected queue,
// a negedge monitor pops and compares every accepted sample FIFO entry.
`timescale 1ns/1ps
module tb_vita_rx_sample_control;

  localparam int W = 32;
  localparam int BASE = 0;

  // Expected entry code: {zero_len, late, broken_chain, ovf, eob, is_data}
  localparam logic [5:0] E_DATA     = 6'b000001;
  localparam logic [5:0] E_DATA_EOB = 6'b000011;
  localparam logic [5:0] E_ZERO     = 6'b100010;
  localparam logic [5:0] E_LATE     = 6'b010010;
  localparam logic [5:0] E_BROKEN   = 6'b001010;
  localparam logic [5:0] E_OVF      = 6'b000110;

  typedef struct {
    bit          imm;
    bit          chain;
    bit          reload;
    int          lines;
    logic [63:0] tm;
  } cmd_t;

  logic          clk, reset, clear, set_stb;
  logic [7:0]    set_addr;
  logic [31:0]   set_data;
  logic [63:0]   vita_time;
  logic          overrun, sample_fifo_dst_rdy_i, sample_fifo_src_rdy_o, run, strobe;
  logic [68+W:0] sample_fifo_o;
  logic [W-1:0]  sample;

  logic [5:0] exp_q[$];
  cmd_t       batch_q[$];
  int         tests_run = 0;
  int         fail_count = 0;
  int         ovr_cnt = 0;
  int         strobe_mode = 0;  // 0 off, 1 every 4th cycle, 2 random
  int         dst_mode = 1;     // 0 forced low, 1 high, 2 random while no strobe
  bit         vt_load = 0;
  logic [63:0] vt_load_val = '0;

  vita_rx_sample_control #(.BASE(BASE), .WIDTH(W), .CMD_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .vita_time(vita_time), .overrun(overrun), .sample_fifo_o(sample_fifo_o),
    .sample_fifo_dst_rdy_i(sample_fifo_dst_rdy_i), .sample_fifo_src_rdy_o(sample_fifo_src_rdy_o),
    .sample(sample), .run(run), .strobe(strobe)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] samp_of(input logic [63:0] t);
    return t[31:0] ^ t[63:32] ^ 32'h5A3C96E1;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Time base, DSP strobe/sample and downstream ready driver
  initial begin
    int cyc;
    cyc = 0;
    vita_time = '0;
    strobe = 1'b0;
    sample = '0;
    sample_fifo_dst_rdy_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (vt_load) begin
        vita_time = vt_load_val;
        vt_load = 0;
      end else begin
        vita_time = vita_time + 64'd1;
      end
      case (strobe_mode)
        0:       strobe = 1'b0;
        1:       strobe = (cyc % 4 == 0);
        default: strobe = ($urandom_range(0, 2) == 0);
      endcase
      sample = strobe ? samp_of(vita_time) : W'($urandom);
      case (dst_mode)
        0:       sample_fifo_dst_rdy_i = 1'b0;
        1:       sample_fifo_dst_rdy_i = 1'b1;
        default: sample_fifo_dst_rdy_i = strobe ? 1'b1 : ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [5:0]    e;
    logic [68+W:0] expw;
    if (reset) begin
      if (overrun) ovr_cnt++;
      if (sample_fifo_src_rdy_o && sample_fifo_dst_rdy_i) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          fail_count++;
          $display("FAIL unexpected_entry: got %h expected no entry", sample_fifo_o);
        end else begin
          e = exp_q.pop_front();
          expw = {e[5:1], vita_time, (e[0] ? samp_of(vita_time) : W'(0))};
          check("entry", 128'(sample_fifo_o), 128'(expw));
        end
      end
    end
  end

  // Reference model: expected entries for a batch queued back to back before any strobe.
  function automatic void model_batch(input logic [63:0] now);
    int   i, n, rem;
    bit   ch, done;
    cmd_t c, nx;
    i = 0;
    n = batch_q.size();
    while (i < n) begin
      c = batch_q[i];
      i++;
      if (c.lines == 0) exp_q.push_back(E_ZERO);
      else if (!c.imm && c.tm < now) exp_q.push_back(E_LATE);
      else begin
        rem = c.lines;
        ch = c.chain;
        done = 0;
        while (!done) begin
          for (int k = 1; k < rem; k++) exp_q.push_back(E_DATA);
          if (!ch) begin
            exp_q.push_back(E_DATA_EOB);
            done = 1;
          end else if (i < n) begin
            nx = batch_q[i];
            i++;
            if (nx.lines > 0) begin
              exp_q.push_back(E_DATA);
              rem = nx.lines;
              ch = nx.chain;
            end else begin
              exp_q.push_back(E_DATA_EOB);
              done = 1;
            end
          end else begin
            exp_q.push_back(E_DATA);
            exp_q.push_back(E_BROKEN);
            done = 1;
            i = n;
          end
        end
      end
    end
  endfunction

  // Driver tasks
  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    set_stb = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
  endtask

  task automatic issue_cmd(input cmd_t c);
    write_reg(8'(BASE), {c.imm, c.chain, c.reload, 29'(c.lines)});
    write_reg(8'(BASE + 1), c.tm[63:32]);
    write_reg(8'(BASE + 2), c.tm[31:0]);
  endtask

  task automatic issue_batch();
    for (int i = 0; i < batch_q.size(); i++) issue_cmd(batch_q[i]);
    @(negedge clk);
  endtask

  function automatic cmd_t mk(input bit imm, input bit chain, input int lines, input logic [63:0] tm);
    cmd_t c;
    c.imm = imm;
    c.chain = chain;
    c.reload = 1'b0;
    c.lines = lines;
    c.tm = tm;
    return c;
  endfunction

  task automatic run_batch();
    model_batch(vita_time);
    issue_batch();
  endtask

  task automatic wait_run(input string name, input int budget);
    int n;
    n = 0;
    while (!run && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(run), 128'(1));
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || run || sample_fifo_src_rdy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 128'(n >= budget), 128'(0));
    if (n >= budget) exp_q.delete();
    strobe_mode = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic set_vita(input logic [63:0] v);
    vt_load_val = v;
    vt_load = 1;
    @(negedge clk);
  endtask

  // Main sequence
  initial begin
    int   ovr_base, nb;
    cmd_t c;
    reset = 1'b0;
    clear = 1'b0;
    set_stb = 1'b0;
    set_addr = '0;
    set_data = '0;
    repeat (3) @(negedge clk);
    check("reset_run", 128'(run), 128'(0));
    check("reset_overrun", 128'(overrun), 128'(0));
    check("reset_src_rdy", 128'(sample_fifo_src_rdy_o), 128'(0));
    check("reset_fifo_o", 128'(sample_fifo_o), 128'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);

    // Immediate, unchained, 8 lines, strobe every 4th cycle
    batch_q.delete();
    batch_q.push_back(mk(1, 0, 8, 64'd0));
    run_batch();
    strobe_mode = 1;
    drain("drain_imm8", 400);
    check("run_low_after_eob", 128'(run), 128'(0));

    // Chain with no follow-up: broken chain
    batch_q.delete();
    batch_q.push_back(mk(1, 1, 10, 64'd0));
    run_batch();
    strobe_mode = 1;
    drain("drain_broken", 400);

    // Zero-length command
    batch_q.delete();
    batch_q.push_back(mk(1, 0, 0, 64'd0));
    run_batch();
    drain("drain_zero", 100);

    // Timed command: run rises the cycle after vita_time matches
    set_vita(64'd0);
    batch_q.delete();
    batch_q.push_back(mk(0, 0, 8, 64'h340));
    run_batch();
    strobe_mode = 1;
    wait_run("timed_run_rise", 2000);
    check("timed_run_time", 128'(vita_time), 128'(64'h341));
    drain("drain_timed", 400);

    // Late command followed by a queued immediate command
    set_vita(64'h500);
    batch_q.delete();
    batch_q.push_back(mk(0, 0, 4, 64'h100));
    batch_q.push_back(mk(1, 0, 3, 64'd0));
    run_batch();
    strobe_mode = 1;
    drain("drain_late", 400);

    // Overrun with queued commands that must be flushed
    set_vita(64'h0000_0003_FFFF_FF00);
    dst_mode = 0;
    ovr_base = ovr_cnt;
    exp_q.push_back(E_OVF);
    batch_q.delete();
    batch_q.push_back(mk(1, 0, 100, 64'd0));
    batch_q.push_back(mk(1, 0, 3, 64'd0));
    batch_q.push_back(mk(1, 0, 0, 64'd0));
    issue_batch();
    wait_run("ovf_run", 50);
    strobe_mode = 1;
    for (int n = 0; n < 50 && !sample_fifo_src_rdy_o; n++) @(negedge clk);
    check("ovf_raised", 128'(sample_fifo_src_rdy_o), 128'(1));
    repeat (6) @(negedge clk);
    check("ovf_held", 128'(sample_fifo_src_rdy_o), 128'(1));
    check("ovf_run_low", 128'(run), 128'(0));
    check("overrun_pulses", 128'(ovr_cnt - ovr_base), 128'(1));
    strobe_mode = 0;
    dst_mode = 1;
    drain("drain_ovf", 100);
    strobe_mode = 1;
    repeat (30) @(negedge clk);
    check("flushed_run", 128'(run), 128'(0));
    strobe_mode = 0;

    // Command FIFO full: 1 running + 16 queued, 17th push dropped
    dst_mode = 2;
    issue_cmd(mk(1, 0, 1, 64'd0));
    @(negedge clk);
    wait_run("full_run", 50);
    for (int k = 0; k < 17; k++) issue_cmd(mk(1, 0, 1, 64'd0));
    for (int k = 0; k < 17; k++) exp_q.push_back(E_DATA_EOB);
    @(negedge clk);
    strobe_mode = 2;
    drain("drain_full", 2000);

    // Clear: stops running, flushes queue, keeps settings registers
    dst_mode = 1;
    issue_cmd(mk(1, 0, 50, 64'd0));
    issue_cmd(mk(1, 0, 0, 64'd0));
    @(negedge clk);
    wait_run("clear_run", 50);
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    check("run_during_clear", 128'(run), 128'(0));
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (10) @(negedge clk);
    check("run_after_clear", 128'(run), 128'(0));
    exp_q.push_back(E_ZERO);
    write_reg(8'(BASE + 2), 32'h0);
    drain("drain_after_clear", 100);

    // Randomized command batches
    set_vita(64'h0000_0010_0000_0000);
    for (int b = 0; b < 8; b++) begin
      batch_q.delete();
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        c.imm = ($urandom_range(0, 4) != 0);
        c.tm = c.imm ? 64'($urandom) : 64'd1;
        c.chain = $urandom_range(0, 1);
        c.lines = $urandom_range(0, 6);
`ifdef VITA_RX_RELOAD_EN
        c.reload = 1'b0;
`else
        c.reload = $urandom_range(0, 1);
`endif
        batch_q.push_back(c);
      end
      dst_mode = 2;
      run_batch();
      strobe_mode = 2;
      drain("drain_random", 1500);
    end

    check("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

  initial begin
    #600000;
    fail_count++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $fatal(1, "watchdog");
  end

endmodule
